// File: rtl/serial_adder_param.sv
// Digit-serial adder/subtractor: W-bit operands are processed D bits per cycle over N = W/D cycles.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output port ovf.
module serial_adder_param #(
  parameter int unsigned W = 32,
  parameter int unsigned D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned N  = W / D;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LastDigit = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          c_out_q, c_out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [D-1:0]  a_dig, b_dig;
  logic [D:0]    dig_res;

  assign a_dig   = a_q[int'(cnt_q) * D +: D];
  assign b_dig   = b_q[int'(cnt_q) * D +: D];
  assign dig_res = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, carry_q};

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the caller's c_in is dropped.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(cnt_q) * D +: D] = dig_res[D-1:0];
        carry_d = dig_res[D];
        if (cnt_q == LastDigit) begin
          c_out_d = dig_res[D];
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
          ovf_d   = a_dig[D-1] ^ b_dig[D-1] ^ dig_res[D-1] ^ dig_res[D];
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_param.sv
// Directed-vector bench for serial_adder_param: a W=32/D=8 instance plus W=8 instances with D=8 and D=1.
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_param;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        c_in, sub, c_out;

  logic        in_valid8, out_ready8, c_in8, sub8;
  logic [7:0]  a8, b8;
  logic        in_ready_n1, out_valid_n1, c_out_n1;
  logic        in_ready_n8, out_valid_n8, c_out_n8;
  logic [7:0]  sum_n1, sum_n8;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf, ovf_n1, ovf_n8;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_param #(.W(32), .D(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  serial_adder_param #(.W(8), .D(8)) u_dut_n1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready_n1),
    .a         (a8),
    .b         (b8),
    .c_in      (c_in8),
    .sub       (sub8),
    .out_valid (out_valid_n1),
    .out_ready (out_ready8),
    .sum       (sum_n1),
    .c_out     (c_out_n1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf_n1)
`endif
  );

  serial_adder_param #(.W(8), .D(1)) u_dut_n8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready_n8),
    .a         (a8),
    .b         (b8),
    .c_in      (c_in8),
    .sub       (sub8),
    .out_valid (out_valid_n8),
    .out_ready (out_ready8),
    .sum       (sum_n8),
    .c_out     (c_out_n8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf_n8)
`endif
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the 32-bit instance; operands are scrambled and in_valid held high
  // after acceptance to show they are ignored until the result is drained.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vc, input logic vs, input logic [31:0] es,
                        input logic ec, input int hold);
    int guard = 0;
`ifdef SERIAL_ADDER_OVF_EN
    logic [31:0] bb;
    logic        eo;
    bb = vs ? ~vb : vb;
    eo = (va[31] == bb[31]) && (es[31] != va[31]);
`endif
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, " in_ready idle"}, in_ready, 1);
    a = va; b = vb; c_in = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    a = $urandom; b = $urandom; c_in = ~vc; sub = ~vs;
    check({tag, " in_ready run"}, in_ready, 0);
    repeat (N - 1) @(posedge clk);
    #1;
    check({tag, " out_valid early"}, out_valid, 0);
    tick();
    check({tag, " out_valid latency"}, out_valid, 1);
    check({tag, " sum"}, sum, es);
    check({tag, " c_out"}, c_out, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, " ovf"}, ovf, eo);
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " held out_valid"}, out_valid, 1);
      check({tag, " held sum"}, {c_out, sum}, {ec, es});
      check({tag, " held in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, " drained in_ready"}, in_ready, 1);
    check({tag, " drained out_valid"}, out_valid, 0);
  endtask

  // Both 8-bit instances accept together; the N=1 one waits in DONE while D=1 finishes.
  task automatic run_small(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic vc, input logic vs, input logic [7:0] es,
                           input logic ec);
    int lat1 = 0;
    int lat8 = 0;
    int cyc  = 0;
    check({tag, " ready"}, {in_ready_n1, in_ready_n8}, 2'b11);
    a8 = va; b8 = vb; c_in8 = vc; sub8 = vs; in_valid8 = 1'b1; out_ready8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    a8 = ~va; b8 = ~vb;
    while ((lat1 == 0 || lat8 == 0) && cyc < 20) begin
      tick();
      cyc++;
      if (out_valid_n1 && lat1 == 0) lat1 = cyc;
      if (out_valid_n8 && lat8 == 0) lat8 = cyc;
    end
    check({tag, " N1 latency"}, lat1, 1);
    check({tag, " N8 latency"}, lat8, 8);
    check({tag, " N1 result"}, {c_out_n1, sum_n1}, {ec, es});
    check({tag, " N8 result"}, {c_out_n8, sum_n8}, {ec, es});
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check({tag, " drained"}, {in_ready_n1, in_ready_n8, out_valid_n1, out_valid_n8}, 4'b1100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rs;
    logic [32:0] ref_res;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; sub8 = 1'b0;
    tick();
    tick();
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", {c_out, sum}, 33'h0);
    check("reset small", {in_ready_n1, out_valid_n1, in_ready_n8, out_valid_n8}, 4'b1010);

    // Reset wins over an in_valid presented in IDLE.
    in_valid = 1'b1; a = 32'h1; b = 32'h1;
    tick();
    check("rst priority in_ready", in_ready, 1);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();

    run_op("v0 ffffffff+1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 0);
    run_op("v1 5-7",          32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("v2 7-5",          32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1);
    run_op("v3 add cin",      32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 0);
    run_op("v4 80000000x2",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 0);
    run_op("v5 sub ignores c", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 0);
    run_op("v6 7fffffff+1",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 0);
    run_op("v7 cin ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 0);
    run_op("v8 digit borrow", 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_00FF, 1'b1, 0);
    run_op("v9 backpressure", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 10);

    // Abort during the second RUN cycle.
    a = 32'h0000_00AA; b = 32'h0000_0011; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort result cleared", {c_out, sum}, 33'h0);
    repeat (6) @(posedge clk);
    #1;
    check("abort no result", out_valid, 0);
    run_op("v10 after abort", 32'h0000_00AA, 32'h0000_0011, 1'b0, 1'b0, 32'h0000_00BB, 1'b0, 0);

    run_small("s0 ff+1",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_small("s1 5-7",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    run_small("s2 7-5",   8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
    run_small("s3 7f+1+c", 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0);
    run_small("s4 80+80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);

    for (int k = 0; k < 100; k++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      ref_res = rs ? ({1'b0, ra} - {1'b0, rb} + 33'h1_0000_0000)
                   : ({1'b0, ra} + {1'b0, rb} + {32'h0, rc});
      run_op($sformatf("r%0d", k), ra, rb, rc, rs, ref_res[31:0], ref_res[32],
             int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
